// File: rtl/coin_input_debounce_pkg.sv
// Shared types, coin constants and the one-hot to coin-value helper for the coin input front end.
package coin_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, WAIT_REL} coin_state_t;

  localparam logic [7:0] COIN_10  = 8'd10;
  localparam logic [7:0] COIN_50  = 8'd50;
  localparam logic [7:0] COIN_100 = 8'd100;

  // Anything that is not exactly one button maps to 0.
  function automatic logic [7:0] coin_value(input logic [2:0] onehot);
    logic [7:0] val;
    case (onehot)
      3'b001:  val = COIN_10;
      3'b010:  val = COIN_50;
      3'b100:  val = COIN_100;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_input_debounce_if.sv
// Button-side and coin-event signals of the coin front end; COIN_CNT_EN adds the accepted-coin count.
interface coin_input_debounce_if;

  logic [2:0] btn;
  logic       c;
  logic [7:0] a;
  logic       busy;
  logic       reject;
`ifdef COIN_CNT_EN
  logic [7:0] coin_cnt;

  modport master (output btn, input c, a, busy, reject, coin_cnt);
  modport slave  (input btn, output c, a, busy, reject, coin_cnt);
`else
  modport master (output btn, input c, a, busy, reject);
  modport slave  (input btn, output c, a, busy, reject);
`endif

endinterface

// File: rtl/coin_input_debounce_btn_debounce.sv
// Two-flop synchronizer plus stable-sample counter; a level is accepted after DEB_CYCLES identical samples.
module btn_debounce #(
  parameter int WIDTH      = 3,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_db
);

  localparam int               CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] btn_s;
  logic [WIDTH-1:0] btn_prev;
  logic [CNT_W-1:0] cnt;
  logic             stable;

  assign stable = (btn_s == btn_prev);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_1   <= '0;
      btn_s    <= '0;
      btn_prev <= '0;
      cnt      <= '0;
      btn_db   <= '0;
    end else begin
      sync_1   <= btn;
      btn_s    <= sync_1;
      btn_prev <= btn_s;
      if (!stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      // The saturated count alone is not enough: a fresh edge arrives with cnt still at max.
      if (stable && (cnt == CNT_MAX)) begin
        btn_db <= btn_s;
      end
    end
  end

endmodule

// File: rtl/coin_input_debounce.sv
// Coin front end: debounces three coin buttons and emits one c/a strobe per accepted press.
// Optional macro COIN_CNT_EN adds an 8-bit wrapping count of accepted coins.
//
// state    | meaning
// IDLE     | waiting for a debounced press
// EMIT     | driving c=1 and the coin value on a for PULSE_LEN cycles
// WAIT_REL | press handled or rejected; waiting for all buttons released
module coin_input_debounce
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int PULSE_LEN  = 1
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  coin_input_debounce_if.slave   bus
);

  localparam int            PW         = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

  coin_state_t   state;
  coin_state_t   state_nxt;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic [7:0]    coin;
  logic [7:0]    coin_nxt;
  logic          reject_q;
  logic          reject_nxt;
  logic [2:0]    btn_db;

  btn_debounce #(
    .WIDTH      (3),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .sys_clk (sys_clk),
    .reset   (reset),
    .btn     (bus.btn),
    .btn_db  (btn_db)
  );

  always_comb begin
    state_nxt  = state;
    pcnt_nxt   = pcnt;
    coin_nxt   = coin;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if ($onehot(btn_db)) begin
          state_nxt = EMIT;
          pcnt_nxt  = PULSE_LOAD;
          coin_nxt  = coin_value(btn_db);
        end else if (btn_db != 3'b000) begin
          state_nxt  = WAIT_REL;
          reject_nxt = 1'b1;
        end
      end
      EMIT: begin
        if (pcnt == '0) begin
          state_nxt = WAIT_REL;
        end else begin
          pcnt_nxt = pcnt - PW'(1);
        end
      end
      WAIT_REL: begin
        if (btn_db == 3'b000) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= IDLE;
      pcnt     <= '0;
      coin     <= 8'd0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      coin     <= coin_nxt;
      reject_q <= reject_nxt;
    end
  end

  assign bus.c      = (state == EMIT);
  assign bus.a      = (state == EMIT) ? coin : 8'd0;
  assign bus.busy   = (state != IDLE);
  assign bus.reject = reject_q;

`ifdef COIN_CNT_EN
  logic [7:0] coin_cnt;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      coin_cnt <= 8'd0;
    end else if ((state == IDLE) && (state_nxt == EMIT)) begin
      coin_cnt <= coin_cnt + 8'd1;
    end
  end

  assign bus.coin_cnt = coin_cnt;
`endif

endmodule

// File: tb/tb_coin_input_debounce.sv
// Directed bench for coin_input_debounce with DEB_CYCLES=4, PULSE_LEN=2; covers COIN_CNT_EN when defined.
module tb_coin_input_debounce;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  coin_input_debounce_if bus();

  coin_input_debounce #(
    .DEB_CYCLES (4),
    .PULSE_LEN  (2)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor state, observed on falling edges. Index 1 is the first falling edge after mon_clear.
  int         m_idx, m_events, m_c_cycles, m_first_c, m_rej, m_first_rej;
  int         m_busy_hi, m_busy_fall, m_a_bad;
  logic [7:0] m_a_val;
  logic       m_c_prev, m_busy_prev;

  task automatic mon_clear();
    m_idx = 0; m_events = 0; m_c_cycles = 0; m_first_c = -1; m_rej = 0; m_first_rej = -1;
    m_busy_hi = 0; m_busy_fall = -1; m_a_bad = 0; m_a_val = 8'd0;
    m_c_prev = bus.c; m_busy_prev = bus.busy;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      m_idx++;
      if (bus.c === 1'b1) begin
        if (m_c_prev !== 1'b1) begin
          m_events++;
          m_a_val = bus.a;
          if (m_first_c < 0) m_first_c = m_idx;
        end else if (bus.a !== m_a_val) begin
          m_a_bad++;
        end
        m_c_cycles++;
      end else if (bus.a !== 8'd0) begin
        m_a_bad++;
      end
      if (bus.reject === 1'b1) begin
        m_rej++;
        if (m_first_rej < 0) m_first_rej = m_idx;
      end
      if (bus.busy === 1'b1) m_busy_hi++;
      if (m_busy_prev === 1'b1 && bus.busy === 1'b0 && m_busy_fall < 0) m_busy_fall = m_idx;
      m_c_prev    = bus.c;
      m_busy_prev = bus.busy;
    end
  endtask

  task automatic test_reset();
    bus.btn = 3'b111;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if ({bus.c, bus.a, bus.busy, bus.reject} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got c=%b a=%0d busy=%b reject=%b, expected all 0",
                 i, bus.c, bus.a, bus.busy, bus.reject);
      end
    end
    bus.btn = 3'b000;
    reset   = 1'b0;
    mon_clear();
    watch(10);
    n_checks++;
    if (m_busy_hi !== 0 || m_events !== 0 || m_rej !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy_cycles=%0d events=%0d rejects=%0d, expected 0/0/0",
               m_busy_hi, m_events, m_rej);
    end
  endtask

  task automatic test_single_press();
    mon_clear();
    bus.btn = 3'b010;
    watch(20);
    n_checks++;
    if (m_first_c !== 8) begin
      n_fail++; $display("FAIL press_latency: c first seen at %0d, expected 8", m_first_c);
    end
    n_checks++;
    if (m_c_cycles !== 2 || m_events !== 1) begin
      n_fail++; $display("FAIL press_strobe: c_cycles=%0d events=%0d, expected 2/1", m_c_cycles, m_events);
    end
    n_checks++;
    if (m_a_val !== 8'd50 || m_a_bad !== 0) begin
      n_fail++; $display("FAIL press_value: a=%0d bad_a=%0d, expected 50/0", m_a_val, m_a_bad);
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL press_busy_held: busy=%b, expected 1", bus.busy);
    end
    mon_clear();
    bus.btn = 3'b000;
    watch(15);
    n_checks++;
    if (m_busy_fall !== 8 || m_events !== 0) begin
      n_fail++; $display("FAIL release_busy: busy fell at %0d events=%0d, expected 8/0", m_busy_fall, m_events);
    end
  endtask

  task automatic test_glitch();
    mon_clear();
    for (int k = 0; k < 15; k++) begin
      bus.btn = (k % 2 == 0) ? 3'b100 : 3'b000;
      watch(2);
    end
    n_checks++;
    if (m_events !== 0 || m_rej !== 0 || m_busy_hi !== 0) begin
      n_fail++;
      $display("FAIL glitch_invisible: events=%0d rejects=%0d busy_cycles=%0d, expected 0/0/0",
               m_events, m_rej, m_busy_hi);
    end
    // Last toggle phase left btn=100 driven for two cycles already.
    mon_clear();
    watch(20);
    n_checks++;
    if (m_events !== 1 || m_a_val !== 8'd100 || m_c_cycles !== 2 || m_first_c !== 6) begin
      n_fail++;
      $display("FAIL glitch_hold: events=%0d a=%0d c_cycles=%0d first=%0d, expected 1/100/2/6",
               m_events, m_a_val, m_c_cycles, m_first_c);
    end
    bus.btn = 3'b000;
    watch(15);
  endtask

  task automatic test_reject();
    mon_clear();
    bus.btn = 3'b011;
    watch(20);
    n_checks++;
    if (m_rej !== 1 || m_first_rej !== 8) begin
      n_fail++; $display("FAIL reject_pulse: count=%0d first=%0d, expected 1/8", m_rej, m_first_rej);
    end
    n_checks++;
    if (m_events !== 0 || m_c_cycles !== 0) begin
      n_fail++; $display("FAIL reject_no_coin: events=%0d c_cycles=%0d, expected 0/0", m_events, m_c_cycles);
    end
    mon_clear();
    bus.btn = 3'b000;
    watch(15);
    n_checks++;
    if (m_events !== 0 || bus.busy !== 1'b0 || m_busy_fall !== 8) begin
      n_fail++;
      $display("FAIL reject_release: events=%0d busy=%b fall=%0d, expected 0/0/8", m_events, bus.busy, m_busy_fall);
    end
  endtask

  task automatic test_added_button();
    mon_clear();
    bus.btn = 3'b001;
    watch(8);
    n_checks++;
    if (m_first_c !== 8) begin
      n_fail++; $display("FAIL added_first: c first seen at %0d, expected 8", m_first_c);
    end
    bus.btn = 3'b011;
    watch(20);
    n_checks++;
    if (m_events !== 1 || m_a_val !== 8'd10 || m_c_cycles !== 2 || m_a_bad !== 0 || m_rej !== 0) begin
      n_fail++;
      $display("FAIL added_ignored: events=%0d a=%0d c_cycles=%0d bad_a=%0d rejects=%0d, expected 1/10/2/0/0",
               m_events, m_a_val, m_c_cycles, m_a_bad, m_rej);
    end
    bus.btn = 3'b000;
    watch(15);
    mon_clear();
    bus.btn = 3'b010;
    watch(20);
    n_checks++;
    if (m_events !== 1 || m_a_val !== 8'd50 || m_first_c !== 8) begin
      n_fail++;
      $display("FAIL added_repress: events=%0d a=%0d first=%0d, expected 1/50/8", m_events, m_a_val, m_first_c);
    end
    bus.btn = 3'b000;
    watch(15);
  endtask

  task automatic test_reset_mid_emit();
    mon_clear();
    bus.btn = 3'b100;
    watch(8);
    n_checks++;
    if (bus.c !== 1'b1 || bus.a !== 8'd100) begin
      n_fail++; $display("FAIL midreset_pre: c=%b a=%0d, expected 1/100", bus.c, bus.a);
    end
    reset   = 1'b1;
    bus.btn = 3'b000;
    @(negedge sys_clk);
    n_checks++;
    if (bus.c !== 1'b0 || bus.a !== 8'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_trunc: c=%b a=%0d busy=%b, expected 0/0/0", bus.c, bus.a, bus.busy);
    end
    reset = 1'b0;
    mon_clear();
    watch(20);
    n_checks++;
    if (m_events !== 0 || m_busy_hi !== 0) begin
      n_fail++; $display("FAIL midreset_replay: events=%0d busy_cycles=%0d, expected 0/0", m_events, m_busy_hi);
    end
  endtask

`ifdef COIN_CNT_EN
  task automatic test_coin_cnt();
    reset = 1'b1;
    bus.btn = 3'b000;
    watch(2);
    reset = 1'b0;
    n_checks++;
    if (bus.coin_cnt !== 8'd0) begin
      n_fail++; $display("FAIL cnt_reset: got %0d expected 0", bus.coin_cnt);
    end
    for (int p = 0; p < 257; p++) begin
      bus.btn = 3'b001;
      watch(10);
      bus.btn = 3'b000;
      watch(10);
    end
    n_checks++;
    if (bus.coin_cnt !== 8'd1) begin
      n_fail++; $display("FAIL cnt_wrap: got %0d expected 1", bus.coin_cnt);
    end
    bus.btn = 3'b110;
    watch(12);
    bus.btn = 3'b000;
    watch(12);
    n_checks++;
    if (bus.coin_cnt !== 8'd1) begin
      n_fail++; $display("FAIL cnt_reject: got %0d expected 1", bus.coin_cnt);
    end
    bus.btn = 3'b010;
    watch(8);
    n_checks++;
    if (bus.coin_cnt !== 8'd2 || bus.c !== 1'b1) begin
      n_fail++; $display("FAIL cnt_emit: cnt=%0d c=%b expected 2/1", bus.coin_cnt, bus.c);
    end
    reset   = 1'b1;
    bus.btn = 3'b000;
    @(negedge sys_clk);
    n_checks++;
    if (bus.coin_cnt !== 8'd0 || bus.c !== 1'b0) begin
      n_fail++; $display("FAIL cnt_midreset: cnt=%0d c=%b expected 0/0", bus.coin_cnt, bus.c);
    end
    reset = 1'b0;
    watch(5);
  endtask
`endif

  initial begin
    bus.btn = 3'b111;
    test_reset();
    test_single_press();
    test_glitch();
    test_reject();
    test_added_button();
    test_reset_mid_emit();
`ifdef COIN_CNT_EN
    test_coin_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_input_debounce.md
# coin_input_debounce

Front-end stage that feeds the soda machine controller's coin inputs `c` and `a[7:0]`. It takes three raw coin push-buttons (10, 50 and 100 units), synchronizes and debounces them, and enforces one coin per press. For each accepted press it emits a single coin event: `c` asserted for `PULSE_LEN` cycles, with `a` carrying the coin value. It sits between the board buttons and the vending FSM, in the `sys_clk` domain.

## Interface
- `DEB_CYCLES`, 1_000_000: number of consecutive identical synchronized samples required before a button level is accepted (20 ms at 50 MHz); must be ≥ 2.
- `PULSE_LEN`, 1: number of cycles that `c` stays high per accepted coin; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `btn` in 3: raw asynchronous buttons, active-high; `btn[0]`=10, `btn[1]`=50, `btn[2]`=100.
- `c` out 1: coin event strobe.
- `a` out 8: coin value, unsigned binary; valid only while `c`=1, and 0 otherwise.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `reject` out 1: one-cycle pulse when a stable multi-button press is discarded.

## Operation
- **Synchronizer:** two flops per bit produce `btn_s`.
- **Debounce counter:**
  - If `btn_s` differs from the previous sample, the counter clears to 0.
  - Otherwise it increments, saturating at `DEB_CYCLES-1`.
  - When the counter reaches `DEB_CYCLES-1`, the debounced vector `btn_db` loads `btn_s`.
- **FSM states and transitions:**
  - IDLE → EMIT when `btn_db` is one-hot.
    - On entry: `a` = the coin value, `c`=1, and the pulse counter loads `PULSE_LEN-1`.
  - IDLE → WAIT_REL when `btn_db` has two or more bits set; `reject`=1 for that one cycle.
  - EMIT: holds `c`=1 and `a` while the pulse counter decrements; moves to WAIT_REL on the cycle after the counter reaches 0.
  - WAIT_REL → IDLE when `btn_db` == 0.
- **One coin per press:** holding a button produces exactly one event. The button must be debounced-released before the next coin is accepted.
- **Added buttons:** a second button pressed during EMIT or WAIT_REL is ignored; the event being emitted is not altered.
- **Width rules:** coin values are 8-bit constants and `a` never exceeds 100. The pulse counter is `$clog2(PULSE_LEN+1)` bits wide; the debounce counter is `$clog2(DEB_CYCLES)` bits wide.

## Timing
- **Reset values:** on reset, `c`=0, `a`=0, `busy`=0, `reject`=0. The FSM goes to IDLE; `btn_db`, the synchronizers and all counters go to 0.
- **Reset mid-EMIT:** the pulse is truncated on the next edge; no event is replayed after reset.
- **Latency:** a press whose level holds steady produces `c`=1 exactly 2 + `DEB_CYCLES` + 1 cycles after the first `sys_clk` edge that samples the new level.
- **Strobe length:** `c` is high for exactly `PULSE_LEN` consecutive cycles, and `a` is stable for the whole window.
- **`busy`** rises in the same cycle as `c` or `reject`. It falls one cycle after `btn_db` returns to 0.
- **Glitches:** any input glitch shorter than `DEB_CYCLES` samples is invisible at the outputs.

## Configuration
- **Macro:** `COIN_CNT_EN`.
- **Defined:**
  - Adds output port `coin_cnt` (out, 8 bits), a count of accepted coins.
  - It increments on the first cycle of each EMIT, wraps from 255 to 0, and resets to 0.
  - Rejected presses are not counted.
- **Undefined:** the port and its register are absent; all other behaviour is identical.

## Structure
- **Package `coin_pkg`:**
  - `typedef enum logic [1:0] {IDLE, EMIT, WAIT_REL} coin_state_t`.
  - Constants `COIN_10`=8'd10, `COIN_50`=8'd50, `COIN_100`=8'd100.
  - Function `coin_value(logic [2:0])` returning the 8-bit value of a one-hot vector.
- **Sub-module `btn_debounce`:**
  - Contents: synchronizer plus stable-counter, parameterized by width and `DEB_CYCLES`.
  - Instantiated once with width 3.
  - It is reusable for the machine's other button inputs.

## Test plan
Run with `DEB_CYCLES`=4 and `PULSE_LEN`=2.
- Reset held for 3 cycles with `btn`=3'b111 → all outputs 0 throughout, FSM in IDLE on release.
- `btn`=3'b010 held for 20 cycles → `c`=1 and `a`=50 for exactly 2 cycles, starting 7 cycles after the first sampling edge. There is one event only, and `busy` falls after release plus debounce.
- `btn[2]` toggles every 2 cycles for 30 cycles, then is held high → no event during the toggling, then a single `a`=100 event once the level is held.
- `btn`=3'b011 held steady → `reject` pulses once, `c` stays 0, and no event occurs until after the release.
- `btn[0]` pressed, then `btn[1]` added during EMIT → one event with `a`=10 and no event for 50. After both are released and `btn[1]` is pressed again → `a`=50.
- With `COIN_CNT_EN` defined: 257 accepted presses → `coin_cnt`=1, and a reset applied mid-EMIT → `coin_cnt`=0 with `c` dropping on the next edge.
